// File: rtl/clock_pkg.sv
// Shared time-of-day limits and reset constants for the timekeeper and the alarm stage.
// The CLOCK_12H_EN build selects the 12-hour reset time in the consumers of this package.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  localparam int RST_HR24 = 0;
  localparam int RST_HR12 = 12;
  localparam int RST_MIN  = 0;
  localparam int RST_SEC  = 0;

  function automatic bcd_t tens_of(input int v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t units_of(input int v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at TENS_MAX:UNITS_MAX; used for seconds and minutes.
module bcd_mod_counter #(
  parameter int TENS_MAX  = 5,
  parameter int UNITS_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);

  logic at_max;

  assign at_max = (tens == 4'(TENS_MAX)) && (units == 4'(UNITS_MAX));
  assign wrap   = inc && at_max && !clear;

  // Each digit steps within its legal BCD range; clear wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clear) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// BCD time-of-day counter with 1 Hz prescaler and button set mode.
// Define CLOCK_12H_EN for 12-hour counting with a PM flag; default is 24-hour.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [3:0] H_1,
  output logic [3:0] H_0,
  output logic [3:0] M_1,
  output logic [3:0] M_0,
  output logic [3:0] sec_led,
  output logic       sec_tick,
  output logic       pm
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] presc;
  logic tick;
  logic hr_prev, min_prev, hr_rise, min_rise;
  logic sec_wrap, min_inc, min_wrap, hr_inc;
  logic [3:0] unused_sec_tens;
  bcd_t hr_t, hr_u;

  assign tick     = !set_en && (presc == CNT_W'(CLK_HZ - 1));
  assign hr_rise  = set_en && inc_hr && !hr_prev;
  assign min_rise = set_en && inc_min && !min_prev;
  assign min_inc  = (tick && sec_wrap) || min_rise;
  assign hr_inc   = (tick && sec_wrap && min_wrap) || hr_rise;

  // Set mode parks the prescaler so leaving it starts a fresh full second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      hr_prev  <= 1'b0;
      min_prev <= 1'b0;
    end else begin
      presc    <= (set_en || tick) ? '0 : presc + 1'b1;
      sec_tick <= tick;
      hr_prev  <= inc_hr;
      min_prev <= inc_min;
    end
  end

  bcd_mod_counter #(.TENS_MAX(SEC_MAX / 10), .UNITS_MAX(SEC_MAX % 10)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (set_en),
    .inc   (tick),
    .tens  (unused_sec_tens),
    .units (sec_led),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(.TENS_MAX(MIN_MAX / 10), .UNITS_MAX(MIN_MAX % 10)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (min_inc),
    .tens  (M_1),
    .units (M_0),
    .wrap  (min_wrap)
  );

`ifdef CLOCK_12H_EN
  logic pm_q;

  // 12-hour sequence 12,01..11,12; only the 11->12 step flips AM/PM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_t <= tens_of(RST_HR12);
      hr_u <= units_of(RST_HR12);
      pm_q <= 1'b0;
    end else if (hr_inc) begin
      if (hr_t == tens_of(HR12_MAX) && hr_u == units_of(HR12_MAX)) begin
        hr_t <= 4'd0;
        hr_u <= 4'd1;
      end else if (hr_t == tens_of(HR12_MAX - 1) && hr_u == units_of(HR12_MAX - 1)) begin
        hr_t <= tens_of(HR12_MAX);
        hr_u <= units_of(HR12_MAX);
        pm_q <= ~pm_q;
      end else if (hr_u == 4'd9) begin
        hr_t <= hr_t + 4'd1;
        hr_u <= 4'd0;
      end else begin
        hr_u <= hr_u + 4'd1;
      end
    end
  end

  assign pm = pm_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_t <= tens_of(RST_HR24);
      hr_u <= units_of(RST_HR24);
    end else if (hr_inc) begin
      if (hr_t == tens_of(HR24_MAX) && hr_u == units_of(HR24_MAX)) begin
        hr_t <= 4'd0;
        hr_u <= 4'd0;
      end else if (hr_u == 4'd9) begin
        hr_t <= hr_t + 4'd1;
        hr_u <= 4'd0;
      end else begin
        hr_u <= hr_u + 4'd1;
      end
    end
  end

  assign pm = 1'b0;
`endif

  assign H_1 = hr_t;
  assign H_0 = hr_u;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper (CLK_HZ=4); honours CLOCK_12H_EN for the 12-hour build.
module tb_clock_timekeeper;

  localparam int CLK_HZ = 4;

`ifdef CLOCK_12H_EN
  localparam logic [15:0] RST_HM = 16'h1200;
  localparam int RST_H = 12;
`else
  localparam logic [15:0] RST_HM = 16'h0000;
  localparam int RST_H = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_en = 1'b0;
  logic inc_hr = 1'b0;
  logic inc_min = 1'b0;
  logic [3:0] H_1, H_0, M_1, M_0, sec_led;
  logic sec_tick, pm;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .inc_hr   (inc_hr),
    .inc_min  (inc_min),
    .H_1      (H_1),
    .H_0      (H_0),
    .M_1      (M_1),
    .M_0      (M_0),
    .sec_led  (sec_led),
    .sec_tick (sec_tick),
    .pm       (pm)
  );

  // Reference time kept as plain integers: hours, minutes, seconds, cycles into the second.
  typedef struct packed {
    int h;
    int m;
    int s;
    int ph;
    bit pm;
    bit tick;
    bit prev_hr;
    bit prev_min;
  } mdl_t;

  mdl_t mdl = '0;

  function automatic mdl_t model_reset();
    mdl_t r = '0;
    r.h = RST_H;
    return r;
  endfunction

  function automatic mdl_t next_hour(input mdl_t c);
    mdl_t n = c;
`ifdef CLOCK_12H_EN
    if (c.h == 11) begin
      n.h = 12;
      n.pm = ~c.pm;
    end else begin
      n.h = (c.h % 12) + 1;
    end
`else
    n.h = (c.h + 1) % 24;
`endif
    return n;
  endfunction

  function automatic mdl_t model_step(input mdl_t c, input bit se, input bit bh, input bit bm);
    mdl_t n = c;
    n.tick = 1'b0;
    if (se) begin
      n.ph = 0;
      n.s = 0;
      if (bm && !c.prev_min) n.m = (c.m + 1) % 60;
      if (bh && !c.prev_hr) n = next_hour(n);
    end else begin
      n.ph = c.ph + 1;
      if (n.ph == CLK_HZ) begin
        n.ph = 0;
        n.tick = 1'b1;
        n.s = c.s + 1;
        if (n.s == 60) begin
          n.s = 0;
          n.m = c.m + 1;
          if (n.m == 60) begin
            n.m = 0;
            n = next_hour(n);
          end
        end
      end
    end
    n.prev_hr = bh;
    n.prev_min = bm;
    return n;
  endfunction

  function automatic logic [31:0] exp_vec(input mdl_t x);
    return {4'h0, 4'(x.h / 10), 4'(x.h % 10), 4'(x.m / 10), 4'(x.m % 10),
            4'(x.s % 10), 3'b0, x.tick, 3'b0, x.pm};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= model_reset();
    else        mdl <= model_step(mdl, set_en, inc_hr, inc_min);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    checkOutput("cycle", {4'h0, H_1, H_0, M_1, M_0, sec_led, 3'b0, sec_tick, 3'b0, pm}, exp_vec(mdl));
  end

  task automatic applyStimulus(input bit se, input bit bh, input bit bm);
    @(negedge clk);
    set_en  = se;
    inc_hr  = bh;
    inc_min = bm;
  endtask

  task automatic setTime(input int h, input int m);
    int guard;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (mdl.h != h && guard < 30) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    guard = 0;
    while (mdl.m != m && guard < 70) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
  endtask

  initial begin
    bit se, bh, bm;

    @(posedge clk); #2;
    checkOutput("reset_hm", {16'h0, H_1, H_0, M_1, M_0}, {16'h0, RST_HM});
    checkOutput("reset_sec", {24'h0, sec_led, 1'b0, sec_tick, 1'b0, pm}, 32'h0);

    @(negedge clk); #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("no_early_tick", {31'h0, sec_tick}, 32'h0);
    @(posedge clk);
    #1 checkOutput("first_tick", {24'h0, sec_tick, 3'b0, sec_led}, {24'h0, 1'b1, 3'b0, 4'd1});
    repeat (36) @(posedge clk);
    #1 checkOutput("ten_seconds", {24'h0, dut.u_sec.tens, sec_led}, 32'h10);

    setTime(RST_H, 59);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (240) @(posedge clk);
    #1 checkOutput("hour_carry", {12'h0, H_1, H_0, M_1, M_0, sec_led}, {12'h0, 16'h0100, 4'd0});

`ifdef CLOCK_12H_EN
    setTime(11, 59);
`else
    setTime(23, 59);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (240) @(posedge clk);
    #1 checkOutput("day_rollover", {12'h0, H_1, H_0, M_1, M_0, 3'b0, pm}, {12'h0, RST_HM, 3'b0,
`ifdef CLOCK_12H_EN
      1'b1});
`else
      1'b0});
`endif
    repeat (14400) @(posedge clk);
`ifdef CLOCK_12H_EN
    #1 checkOutput("next_hour", {12'h0, H_1, H_0, M_1, M_0, 3'b0, pm}, {12'h0, 16'h0100, 4'd1});
`else
    #1 checkOutput("next_hour", {12'h0, H_1, H_0, M_1, M_0, 3'b0, pm}, {12'h0, 16'h0100, 4'd0});
`endif

    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1 checkOutput("held_min", {16'h0, H_1, H_0, M_1, M_0}, 32'h0101);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setTime(1, 59);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 checkOutput("min_wrap_no_carry", {16'h0, H_1, H_0, M_1, M_0}, 32'h0100);
    applyStimulus(1'b1, 1'b0, 1'b0);

    setTime(9, 30);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 checkOutput("both_buttons", {16'h0, H_1, H_0, M_1, M_0}, 32'h1031);
    applyStimulus(1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("async_reset", {8'h0, H_1, H_0, M_1, M_0, sec_led, 3'b0, sec_tick},
                   {8'h0, RST_HM, 4'd0, 4'd0});
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("post_reset_quiet", {31'h0, sec_tick}, 32'h0);
    end
    @(posedge clk);
    #1 checkOutput("post_reset_tick", {31'h0, sec_tick}, 32'h1);

    se = 1'b0; bh = 1'b0; bm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) se = ~se;
      if ($urandom_range(0, 3) == 0) bh = ~bh;
      if ($urandom_range(0, 3) == 0) bm = ~bm;
      applyStimulus(se, bh, bm);
      if ($urandom_range(0, 799) == 0) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
